dmac_fifo: RTL and testbench

DMAC_FIFO -- requirements
Module: DMAC_FIFO

---
 rtl/dmac_fifo.sv | 75 +++++++
 tb/tb_dmac_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_fifo.sv
// Show-ahead synchronous FIFO between the DMA channel arbiter and the data mover.
// Wrap-bit pointers give full/empty; occupancy is kept in a separate registered counter.
module dmac_fifo #(
    parameter int unsigned DEPTH_LG2 = 4,
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [DATA_SIZE-1:0] src_data_i,
    output logic                 dst_valid_o,
    input  logic                 dst_ready_i,
    output logic [DATA_SIZE-1:0] dst_data_o,
    output logic [DEPTH_LG2:0]   cnt_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LG2;

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [DEPTH_LG2:0]   r_wr_ptr;
    logic [DEPTH_LG2:0]   r_rd_ptr;
    logic [DEPTH_LG2:0]   r_cnt;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // Flags come straight from the pointers so they follow an asynchronous reset at once.
    always_comb begin
        w_full  = (r_wr_ptr[DEPTH_LG2-1:0] == r_rd_ptr[DEPTH_LG2-1:0]) &&
                  (r_wr_ptr[DEPTH_LG2] != r_rd_ptr[DEPTH_LG2]);
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_push  = src_valid_i & ~w_full;
        w_pop   = dst_ready_i & ~w_empty;
    end

    assign src_ready_o = ~w_full;
    assign dst_valid_o = ~w_empty;
    assign dst_data_o  = r_mem[r_rd_ptr[DEPTH_LG2-1:0]];
    assign cnt_o       = r_cnt;
    assign full_o      = w_full;
    assign empty_o     = w_empty;

    // Storage is deliberately left out of reset; the head is only meaningful while valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_LG2-1:0]] <= src_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_fifo.sv
// Directed and random bench for dmac_fifo; a queue reference model is compared every cycle
// and directed scenarios add hand-computed literal expectations.
module tb_dmac_fifo;

    localparam int unsigned LG2   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 32;

    logic            clk;
    logic            rst_n;
    logic            src_valid_i;
    logic            src_ready_o;
    logic [DW-1:0]   src_data_i;
    logic            dst_valid_o;
    logic            dst_ready_i;
    logic [DW-1:0]   dst_data_o;
    logic [LG2:0]    cnt_o;
    logic            full_o;
    logic            empty_o;

    int total;
    int bad;
    bit chk_en;

    logic [DW-1:0] model_q[$];

    dmac_fifo #(
        .DEPTH_LG2(LG2),
        .DATA_SIZE(DW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid_i(src_valid_i),
        .src_ready_o(src_ready_o),
        .src_data_i (src_data_i),
        .dst_valid_o(dst_valid_o),
        .dst_ready_i(dst_ready_i),
        .dst_data_o (dst_data_o),
        .cnt_o      (cnt_o),
        .full_o     (full_o),
        .empty_o    (empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO is a bounded queue; accept when not full, release the oldest when not empty.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            bit do_push;
            bit do_pop;
            do_push = src_valid_i && (model_q.size() < DEPTH);
            do_pop  = dst_ready_i && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(src_data_i);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_cnt",   64'(cnt_o),       64'(model_q.size()));
            chk("m_full",  64'(full_o),      64'(model_q.size() == DEPTH));
            chk("m_empty", 64'(empty_o),     64'(model_q.size() == 0));
            chk("m_ready", 64'(src_ready_o), 64'(model_q.size() != DEPTH));
            chk("m_valid", 64'(dst_valid_o), 64'(model_q.size() != 0));
            if (model_q.size() > 0) chk("m_data", 64'(dst_data_o), 64'(model_q[0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        chk_en      = 1'b0;
        rst_n       = 1'b1;
        src_valid_i = 1'b0;
        src_data_i  = '0;
        dst_ready_i = 1'b0;
        #1 rst_n = 1'b0;
        cyc();
        cyc();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_full",  64'(full_o), 64'd0);
        chk("rst_cnt",   64'(cnt_o), 64'd0);
        chk("rst_ready", 64'(src_ready_o), 64'd1);
        chk("rst_valid", 64'(dst_valid_o), 64'd0);

        // Single beat; no bypass before the edge
        src_valid_i = 1'b1;
        src_data_i  = 32'hA5A5_0001;
        #1 chk("no_bypass", 64'(dst_valid_o), 64'd0);
        cyc();
        src_valid_i = 1'b0;
        chk("one_valid", 64'(dst_valid_o), 64'd1);
        chk("one_data",  64'(dst_data_o), 64'hA5A5_0001);
        chk("one_cnt",   64'(cnt_o), 64'd1);
        dst_ready_i = 1'b1;
        cyc();
        dst_ready_i = 1'b0;
        chk("one_empty", 64'(empty_o), 64'd1);

        // Push into empty while dst_ready_i is high
        src_valid_i = 1'b1;
        src_data_i  = 32'h0000_1234;
        dst_ready_i = 1'b1;
        cyc();
        src_valid_i = 1'b0;
        dst_ready_i = 1'b0;
        chk("empty_push_cnt",  64'(cnt_o), 64'd1);
        chk("empty_push_data", 64'(dst_data_o), 64'h1234);
        dst_ready_i = 1'b1;
        cyc();
        dst_ready_i = 1'b0;

        // Fill
        for (int i = 0; i < 16; i++) begin
            src_valid_i = 1'b1;
            src_data_i  = DW'(i);
            cyc();
        end
        chk("fill_full",  64'(full_o), 64'd1);
        chk("fill_cnt",   64'(cnt_o), 64'd16);
        chk("fill_ready", 64'(src_ready_o), 64'd0);
        src_data_i = 32'd100;
        cyc();
        chk("hold_cnt",  64'(cnt_o), 64'd16);
        chk("hold_head", 64'(dst_data_o), 64'd0);

        // Pop at full: push refused, pop proceeds
        dst_ready_i = 1'b1;
        cyc();
        dst_ready_i = 1'b0;
        chk("popfull_cnt",  64'(cnt_o), 64'd15);
        chk("popfull_head", 64'(dst_data_o), 64'd1);
        chk("popfull_full", 64'(full_o), 64'd0);
        cyc();
        src_valid_i = 1'b0;
        chk("held_accept_cnt", 64'(cnt_o), 64'd16);
        chk("held_accept_full", 64'(full_o), 64'd1);
        dst_ready_i = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("drain_order", 64'(dst_data_o), 64'(i));
            cyc();
        end
        chk("drain_last", 64'(dst_data_o), 64'd100);
        cyc();
        dst_ready_i = 1'b0;
        chk("drain_empty", 64'(empty_o), 64'd1);

        // Streaming 0..39 at constant occupancy
        src_valid_i = 1'b1;
        src_data_i  = 32'd0;
        cyc();
        dst_ready_i = 1'b1;
        for (int i = 1; i < 40; i++) begin
            src_data_i = DW'(i);
            cyc();
            chk("stream_cnt",  64'(cnt_o), 64'd1);
            chk("stream_head", 64'(dst_data_o), 64'(i));
        end
        src_valid_i = 1'b0;
        cyc();
        dst_ready_i = 1'b0;
        chk("stream_empty", 64'(empty_o), 64'd1);

        // Reset mid-operation with no clock edge
        for (int i = 0; i < 7; i++) begin
            src_valid_i = 1'b1;
            src_data_i  = 32'hC000_0000 + DW'(i);
            cyc();
        end
        src_valid_i = 1'b0;
        chk("pre_rst_cnt", 64'(cnt_o), 64'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(dst_valid_o), 64'd0);
        chk("arst_cnt",   64'(cnt_o), 64'd0);
        chk("arst_ready", 64'(src_ready_o), 64'd1);
        chk("arst_empty", 64'(empty_o), 64'd1);
        src_valid_i = 1'b1;
        src_data_i  = 32'h0000_DEAD;
        cyc();
        chk("in_rst_cnt", 64'(cnt_o), 64'd0);
        rst_n      = 1'b1;
        src_data_i = 32'h0000_BEEF;
        cyc();
        src_valid_i = 1'b0;
        chk("post_rst_cnt",  64'(cnt_o), 64'd1);
        chk("post_rst_data", 64'(dst_data_o), 64'hBEEF);
        dst_ready_i = 1'b1;
        cyc();
        dst_ready_i = 1'b0;

        // Random stress against the queue model
        for (int i = 0; i < 10000; i++) begin
            src_valid_i = 1'($urandom_range(0, 1));
            dst_ready_i = 1'($urandom_range(0, 1));
            src_data_i  = DW'($urandom);
            cyc();
        end
        src_valid_i = 1'b0;
        dst_ready_i = 1'b0;
        cyc();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
